// File: rtl/mmcm_reset_sequencer_if.sv
// Signal bundle between the MMCM reset sequencer and the rest of the top level:
// the MMCM lock input, the user restart request and every sequencer output.
//
// Handshake semantics: there is no valid/ready pair on this bundle. `restart`
// is a single-cycle request sampled on every clk edge and always accepted.
// `mmcm_locked` is a level from another clock domain. All outputs are levels
// that are valid every cycle.
interface mmcm_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic            restart;
    logic            mmcm_locked;
    logic            mmcm_rst;
    logic            design_rst;
    logic            clocks_ready;
    logic            fault;
    logic [RC_W-1:0] retry_count;
    logic [7:0]      lock_loss_count;
    logic [2:0]      state_o;

    // Sequencer side
    modport slave (
        input  restart,
        input  mmcm_locked,
        output mmcm_rst,
        output design_rst,
        output clocks_ready,
        output fault,
        output retry_count,
        output lock_loss_count,
        output state_o
    );

    // Top-level / MMCM side
    modport master (
        output restart,
        output mmcm_locked,
        input  mmcm_rst,
        input  design_rst,
        input  clocks_ready,
        input  fault,
        input  retry_count,
        input  lock_loss_count,
        input  state_o
    );
endinterface

// File: rtl/mmcm_reset_sequencer.sv
// Pixel-clock MMCM reset/lock sequencer. Pulses the MMCM reset, waits for a
// stable synchronized LOCKED, then releases the design-wide reset. Retries a
// bounded number of times on lock timeout and re-runs on lock loss or restart.
module mmcm_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int STABLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mmcm_reset_sequencer_if.slave bus
);
    localparam int RC_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [RC_W-1:0]  retry_count;
    logic [7:0]       lock_loss_count;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             locked_s;
    logic             cnt_clr;
    logic             retry_inc;
    logic             retry_clr;
    logic             loss_inc;
    logic             mmcm_rst_q;
    logic             design_rst_q;
    logic             clocks_ready_q;
    logic             fault_q;

    // Bring the asynchronous LOCKED into the clk domain; only locked_s is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.mmcm_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state and counter-control decode; restart overrides every transition.
    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        loss_inc  = 1'b0;
        if (bus.restart) begin
            state_n   = S_HOLD;
            retry_clr = 1'b1;
            // A lock loss seen in the same cycle as restart is still counted.
            loss_inc  = (state == S_RUN) && !locked_s;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_n = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_LIMIT) begin
                            state_n = S_FAULT;
                        end else begin
                            state_n   = S_HOLD;
                            retry_inc = 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    // A lock glitch restarts the lock wait without using a retry.
                    if (!locked_s) begin
                        state_n = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_n   = S_RUN;
                        retry_clr = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_n  = S_HOLD;
                        loss_inc = 1'b1;
                    end
                end
                S_FAULT: state_n = S_FAULT;
                default: state_n = S_HOLD;
            endcase
        end
        // Restart in HOLD must also restart the hold count.
        cnt_clr = (state_n != state) || bus.restart;
    end

    // Sequencer state, shared cycle counter, retry/loss counters and Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_HOLD;
            cnt             <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            mmcm_rst_q      <= 1'b1;
            design_rst_q    <= 1'b1;
            clocks_ready_q  <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state <= state_n;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (retry_clr) begin
                retry_count <= '0;
            end else if (retry_inc) begin
                retry_count <= retry_count + RC_W'(1);
            end

            if (loss_inc && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end

            mmcm_rst_q     <= (state_n == S_HOLD) || (state_n == S_FAULT);
            design_rst_q   <= (state_n != S_RUN);
            clocks_ready_q <= (state_n == S_RUN);
            fault_q        <= (state_n == S_FAULT);
        end
    end

    assign bus.mmcm_rst        = mmcm_rst_q;
    assign bus.design_rst      = design_rst_q;
    assign bus.clocks_ready    = clocks_ready_q;
    assign bus.fault           = fault_q;
    assign bus.retry_count     = retry_count;
    assign bus.lock_loss_count = lock_loss_count;
    assign bus.state_o         = state;
endmodule

// File: doc/mmcm_reset_sequencer.md
# mmcm_reset_sequencer

Sequences reset and lock for the pixel-clock MMCM. It runs on the free-running 100 MHz board clock, pulses the MMCM reset, and waits for a stable LOCKED. It then releases a design-wide reset and `clocks_ready`. On lock timeout it retries a bounded number of times, and it recovers from loss of lock or a user restart. It sits in the top level between the board clock/reset pins, the MMCM instance and the per-domain reset synchronizers.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 16: cycles `mmcm_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 4096: cycles to wait for lock before retrying (≥2).
- `STABLE_CYCLES`, 256: consecutive cycles synchronized lock must stay high before release (≥1).
- `MAX_RETRIES`, 3: retries allowed after the first attempt before `fault` is raised.
- `SYNC_STAGES`, 2: flip-flop stages on `mmcm_locked` (≥2).

Ports:
- `clk`, in, 1: board clock, 100 MHz, free-running.
- `rst`, in, 1: reset, synchronous to `clk`, active-high.
- `restart`, in, 1: single-cycle request to re-run the full sequence.
- `mmcm_locked`, in, 1: MMCM LOCKED, asynchronous to `clk`.
- `mmcm_rst`, out, 1: drives MMCM RST.
- `design_rst`, out, 1: active-high reset for downstream logic, fed to per-domain synchronizers.
- `clocks_ready`, out, 1: high only in RUN.
- `fault`, out, 1: sticky; retry budget exhausted.
- `retry_count`, out, $clog2(MAX_RETRIES+1): retries used in the current bring-up.
- `lock_loss_count`, out, 8: saturating count of lock losses seen in RUN.
- `state_o`, out, 3: current state encoding for debug.

## Operation
- States and encodings: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- `mmcm_locked` passes through a `SYNC_STAGES` flop chain to give `locked_s`. Only `locked_s` is used.
- A single cycle counter `cnt` is used. Its width covers the maximum of the three cycle parameters, and it clears on every state change.
- HOLD:
  - `mmcm_rst`=1.
  - When `cnt`==`RST_HOLD_CYCLES`-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `mmcm_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt`==`LOCK_TIMEOUT_CYCLES`-1: if `retry_count`==`MAX_RETRIES`, go to FAULT; else increment `retry_count` and go to HOLD.
- STABLE:
  - If `locked_s`=0, go back to WAIT_LOCK. The timeout restarts from 0 and no retry is consumed.
  - When `cnt`==`STABLE_CYCLES`-1 with `locked_s`=1, go to RUN and clear `retry_count`.
- RUN:
  - If `locked_s`=0, go to HOLD and increment `lock_loss_count`, saturating at 255.
- FAULT:
  - `mmcm_rst`=1 and `fault`=1. The state is held until `rst` or `restart`.
- `restart` in any state: go to HOLD next cycle, clear `retry_count`, clear `fault`.
  - In HOLD, `restart` restarts the hold count.
  - `restart` has priority over every other transition in the same cycle.
  - Simultaneous `restart` and lock loss in RUN: go to HOLD and still increment `lock_loss_count`.
- Output decode (Moore, purely from state):
  - `design_rst` = (state≠RUN).
  - `clocks_ready` = (state==RUN).
  - `mmcm_rst` = (state==HOLD or FAULT).
  - `fault` = (state==FAULT).

## Timing
- `rst` is sampled on the rising edge of `clk`. While it is high, and on the first edge after it:
  - state=HOLD, `cnt`=0, all sync flops 0;
  - `mmcm_rst`=1, `design_rst`=1, `clocks_ready`=0, `fault`=0;
  - `retry_count`=0, `lock_loss_count`=0, `state_o`=0.
- `rst` high mid-sequence returns to HOLD on the next edge, whatever the current state.
- `mmcm_rst` is high for exactly `RST_HOLD_CYCLES` cycles per attempt.
- Lock input to `locked_s` latency is `SYNC_STAGES` cycles. From `locked_s` to the STABLE state is 1 cycle.
- With `locked_s` already high when WAIT_LOCK is entered, the sequence takes `RST_HOLD_CYCLES` + 1 + `STABLE_CYCLES` cycles from the first post-reset edge to RUN. In that first RUN cycle, `design_rst`=0 and `clocks_ready`=1.
- A lock drop in RUN asserts `design_rst` `SYNC_STAGES`+1 cycles after `mmcm_locked` falls.
- A glitch on `locked_s` shorter than `STABLE_CYCLES` never reaches RUN.
- The worst-case path to FAULT is (`MAX_RETRIES`+1)×(`RST_HOLD_CYCLES`+`LOCK_TIMEOUT_CYCLES`) cycles after reset.

## Test plan
All scenarios use `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2, `SYNC_STAGES`=2.

- Nominal bring-up: `mmcm_locked` held 1. Release `rst` → `mmcm_rst` high for cycles 0–3; `design_rst` falls and `clocks_ready` rises at cycle 13; `retry_count`=0.
- Timeout to fault: `mmcm_locked` held 0 → three HOLD pulses of 4 cycles each; `retry_count` goes 1 then 2; `fault`=1 and `state_o`=4 at cycle 72; `design_rst` stays 1 throughout.
- Unstable lock: lock rises, then drops for 1 cycle after 5 stable cycles → state returns to WAIT_LOCK with no retry consumed. With lock then held, RUN is reached 1+8 cycles after `locked_s` returns high.
- Loss of lock in RUN: drop `mmcm_locked` → `design_rst`=1 and `mmcm_rst`=1 three cycles later; `lock_loss_count`=1; with lock restored, the sequence re-runs to RUN. Forcing 300 losses leaves `lock_loss_count`=255.
- Restart from FAULT and mid-STABLE: a `restart` pulse clears `fault` and `retry_count` and enters HOLD next cycle. `restart` in the same cycle as lock loss in RUN gives HOLD with `lock_loss_count` incremented once.
- Reset mid-WAIT_LOCK: assert `rst` for 1 cycle → next edge has all outputs at their reset values and `cnt` restarted.
